// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if: request, store-handshake, load-return and memory-pin bundle for mem_burst_ctrl
//   master (controller side): inputs  start, isLoad, baseAddr, len, wrData, wrValid, memDataOut
//                             outputs busy, done, wrReady, rdData, rdValid, memAddress, memDataIn, En, MemR, MemW
//   slave  (datapath/memory side): the same signals with the directions reversed
interface mem_burst_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 4
);
   logic              start;
   logic              isLoad;
   logic [ADDR_W-1:0] baseAddr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] wrData;
   logic              wrValid;
   logic              wrReady;
   logic [DATA_W-1:0] rdData;
   logic              rdValid;
   logic [ADDR_W-1:0] memAddress;
   logic [DATA_W-1:0] memDataIn;
   logic              En;
   logic              MemR;
   logic              MemW;
   logic [DATA_W-1:0] memDataOut;
   modport master (
      input  start, isLoad, baseAddr, len, wrData, wrValid, memDataOut,
      output busy, done, wrReady, rdData, rdValid, memAddress, memDataIn, En, MemR, MemW
   );
   modport slave (
      output start, isLoad, baseAddr, len, wrData, wrValid, memDataOut,
      input  busy, done, wrReady, rdData, rdValid, memAddress, memDataIn, En, MemR, MemW
   );
endinterface

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst load/store initiator driving a synchronous 16-bit data memory one word per cycle
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mem_burst_ctrl_if.master -- request (start/isLoad/baseAddr/len, busy/done),
//            store handshake (wrData/wrValid/wrReady), load return (rdData/rdValid),
//            memory pins (memAddress/memDataIn/En/MemR/MemW, memDataOut)
module mem_burst_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 4
) (
   input logic             clk,
   input logic             rst_n,
   mem_burst_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              is_rd, wr_go;
   logic [ADDR_W-1:0] addr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         rd_pend_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = bus.isLoad ? RD : WR;
            base_d  = bus.baseAddr;
            len_d   = bus.len;
            cnt_d   = '0;
         end
         RD: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == len_q) ? RD_WAIT : RD;
         end
         RD_WAIT: state_d = DONE;
         WR: if (bus.wrValid) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == len_q) ? DONE : WR;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // Memory dataOut is valid the cycle after a read issue; capture it on the following edge.
   always_comb begin
      rd_pend_d  = (state_q == RD);
      rd_valid_d = rd_pend_q;
      rd_data_d  = rd_pend_q ? bus.memDataOut : rd_data_q;
   end
   assign is_rd = (state_q == RD);
   assign wr_go = (state_q == WR) && bus.wrValid;
   // Address arithmetic wraps modulo 2^ADDR_W.
   assign addr  = base_q + ADDR_W'(cnt_q);
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.wrReady    = (state_q == WR);
   assign bus.rdData     = rd_data_q;
   assign bus.rdValid    = rd_valid_q;
   assign bus.En         = is_rd | wr_go;
   assign bus.MemR       = is_rd;
   assign bus.MemW       = wr_go;
   assign bus.memAddress = (is_rd | wr_go) ? addr : '0;
   assign bus.memDataIn  = wr_go ? bus.wrData : '0;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed self-checking bench for mem_burst_ctrl with a synchronous memory model
module tb_mem_burst_ctrl;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] mem [0:65535];
   logic [15:0] exp_rd [4] = '{16'h000A, 16'h0014, 16'h0028, 16'h003C};
   logic [15:0] wr_vals [3] = '{16'h1111, 16'h2222, 16'h3333};
   mem_burst_ctrl_if bus ();
   mem_burst_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.En && bus.MemR) bus.memDataOut <= mem[bus.memAddress];
      if (bus.En && bus.MemW) mem[bus.memAddress] <= bus.memDataIn;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      bus.memDataOut = 16'h0000;
      bus.start = 1'b0; bus.isLoad = 1'b0; bus.baseAddr = '0; bus.len = '0;
      bus.wrData = '0; bus.wrValid = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      // reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.start = 1'($urandom); bus.isLoad = 1'($urandom); bus.baseAddr = 16'($urandom);
         bus.len = 4'($urandom); bus.wrData = 16'($urandom); bus.wrValid = 1'($urandom);
         #1;
         chk($sformatf("rst%0d busy", i), bus.busy, 0);
         chk($sformatf("rst%0d done", i), bus.done, 0);
         chk($sformatf("rst%0d En", i), bus.En, 0);
         chk($sformatf("rst%0d MemR/MemW", i), {bus.MemR, bus.MemW}, 0);
         chk($sformatf("rst%0d wrReady/rdValid", i), {bus.wrReady, bus.rdValid}, 0);
         chk($sformatf("rst%0d rdData", i), bus.rdData, 0);
         chk($sformatf("rst%0d memAddress", i), bus.memAddress, 0);
         chk($sformatf("rst%0d memDataIn", i), bus.memDataIn, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.start = 1'b0; bus.wrValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk($sformatf("post-rst%0d busy", i), bus.busy, 0);
         chk($sformatf("post-rst%0d En", i), bus.En, 0);
      end
      // single read
      mem[9] = 16'h0044;
      @(negedge clk);
      bus.start = 1'b1; bus.isLoad = 1'b1; bus.baseAddr = 16'h0009; bus.len = 4'd0;
      #1 chk("rd1 c0 busy", bus.busy, 0);
      @(negedge clk); bus.start = 1'b0; #1;
      chk("rd1 c1 En/MemR/MemW", {bus.En, bus.MemR, bus.MemW}, 3'b110);
      chk("rd1 c1 addr", bus.memAddress, 16'h0009);
      chk("rd1 c1 busy", bus.busy, 1);
      @(negedge clk); #1;
      chk("rd1 c2 En", bus.En, 0);
      chk("rd1 c2 rdValid", bus.rdValid, 0);
      @(negedge clk); #1;
      chk("rd1 c3 rdValid", bus.rdValid, 1);
      chk("rd1 c3 rdData", bus.rdData, 16'h0044);
      chk("rd1 c3 done", bus.done, 1);
      @(negedge clk); #1;
      chk("rd1 c4 busy", bus.busy, 0);
      chk("rd1 c4 rdValid", bus.rdValid, 0);
      chk("rd1 c4 rdData hold", bus.rdData, 16'h0044);
      // burst read with start pulsed mid-burst and in the DONE cycle
      for (int i = 0; i < 4; i++) mem[i] = exp_rd[i];
      @(negedge clk);
      bus.start = 1'b1; bus.isLoad = 1'b1; bus.baseAddr = 16'h0000; bus.len = 4'd3;
      #1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         bus.start = (c == 2 || c == 6); bus.isLoad = 1'b0; bus.baseAddr = 16'h0100;
         bus.len = 4'd1; bus.wrValid = 1'b1; bus.wrData = 16'hDEAD;
         #1;
         chk($sformatf("brd c%0d busy", c), bus.busy, (c <= 6));
         chk($sformatf("brd c%0d done", c), bus.done, (c == 6));
         chk($sformatf("brd c%0d En", c), bus.En, (c <= 4));
         chk($sformatf("brd c%0d MemW", c), bus.MemW, 0);
         chk($sformatf("brd c%0d rdValid", c), bus.rdValid, (c >= 3 && c <= 6));
         if (c <= 4) chk($sformatf("brd c%0d addr", c), bus.memAddress, c - 1);
         if (c >= 3 && c <= 6) chk($sformatf("brd c%0d rdData", c), bus.rdData, exp_rd[c-3]);
      end
      bus.wrValid = 1'b0;
      // wrapping write with a 2-cycle stall before the second word
      @(negedge clk);
      bus.start = 1'b1; bus.isLoad = 1'b0; bus.baseAddr = 16'hFFFF; bus.len = 4'd2;
      #1 chk("wr c0 busy", bus.busy, 0);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.wrValid = (c == 1 || c == 4 || c == 5);
         bus.wrData = (c == 1) ? wr_vals[0] : (c == 4) ? wr_vals[1] : (c == 5) ? wr_vals[2] : 16'hBEEF;
         #1;
         chk($sformatf("wr c%0d En", c), bus.En, bus.wrValid);
         chk($sformatf("wr c%0d MemR", c), bus.MemR, 0);
         chk($sformatf("wr c%0d wrReady", c), bus.wrReady, (c <= 5));
         chk($sformatf("wr c%0d done", c), bus.done, (c == 6));
         chk($sformatf("wr c%0d busy", c), bus.busy, (c <= 6));
         if (c == 1) chk("wr c1 addr", bus.memAddress, 16'hFFFF);
         if (c == 4) chk("wr c4 addr", bus.memAddress, 16'h0000);
         if (c == 5) chk("wr c5 addr", bus.memAddress, 16'h0001);
         if (bus.wrValid) chk($sformatf("wr c%0d dataIn", c), bus.memDataIn, bus.wrData);
      end
      chk("wr mem[FFFF]", mem[16'hFFFF], 16'h1111);
      chk("wr mem[0000]", mem[16'h0000], 16'h2222);
      chk("wr mem[0001]", mem[16'h0001], 16'h3333);
      chk("wr mem[0002] untouched", mem[16'h0002], 16'h0028);
      // readback across the wrap
      @(negedge clk);
      bus.wrValid = 1'b0;
      bus.start = 1'b1; bus.isLoad = 1'b1; bus.baseAddr = 16'hFFFF; bus.len = 4'd2;
      #1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk); bus.start = 1'b0; #1;
         chk($sformatf("rb c%0d rdValid", c), bus.rdValid, (c >= 3 && c <= 5));
         chk($sformatf("rb c%0d done", c), bus.done, (c == 5));
         if (c >= 3 && c <= 5) chk($sformatf("rb c%0d rdData", c), bus.rdData, wr_vals[c-3]);
      end
      // reset during the second word of a 4-word write
      for (int i = 16'h20; i < 16'h24; i++) mem[i] = 16'h0000;
      @(negedge clk);
      bus.start = 1'b1; bus.isLoad = 1'b0; bus.baseAddr = 16'h0020; bus.len = 4'd3; bus.wrValid = 1'b0;
      #1;
      @(negedge clk);
      bus.start = 1'b0; bus.wrValid = 1'b1; bus.wrData = 16'hAAAA;
      #1 chk("mr c1 En", bus.En, 1);
      chk("mr c1 addr", bus.memAddress, 16'h0020);
      @(negedge clk);
      bus.wrData = 16'hBBBB; rst_n = 1'b0;
      #1;
      chk("mr c2 En", bus.En, 0);
      chk("mr c2 MemW", bus.MemW, 0);
      chk("mr c2 busy", bus.busy, 0);
      chk("mr c2 wrReady", bus.wrReady, 0);
      chk("mr c2 memAddress", bus.memAddress, 0);
      @(negedge clk); #1;
      chk("mr c3 busy", bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1; bus.wrValid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("mr idle busy", bus.busy, 0);
      chk("mr mem[20]", mem[16'h0020], 16'hAAAA);
      chk("mr mem[21]", mem[16'h0021], 16'h0000);
      chk("mr mem[22]", mem[16'h0022], 16'h0000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Memory-side initiator for the 16-bit data memory of the multi-cycle processor. It accepts a single-word or burst load/store request from the datapath and drives the memory's `En`/`MemR`/`MemW`/address/data pins one word per cycle. Read data is returned on a registered strobe, and write data is pulled through a valid/ready handshake. It replaces ad-hoc control-unit driving of the memory pins and enables load/store-multiple instructions.

## Interface
Parameters:
- `DATA_W`, 16: data word width; must match the memory.
- `ADDR_W`, 16: address width; word-addressed.
- `LEN_W`, 4: width of the burst-length field. A burst is `len+1` words, maximum 16.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; accepted only in a cycle where `busy`=0.
- `isLoad`  in  1  sampled with `start`; 1 = read burst, 0 = write burst.
- `baseAddr`  in  ADDR_W  first word address, sampled with `start`.
- `len`  in  LEN_W  word count minus one, sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle.
- `done`  out  1  one-cycle pulse at burst completion.
- `wrData`  in  DATA_W  store data.
- `wrValid`  in  1  `wrData` is valid.
- `wrReady`  out  1  controller can take a store word this cycle.
- `rdData`  out  DATA_W  registered load data; holds its value between strobes.
- `rdValid`  out  1  one-cycle strobe per loaded word.
- `memAddress`  out  ADDR_W  to memory `address`.
- `memDataIn`  out  DATA_W  to memory `dataIn`.
- `En`, `MemR`, `MemW`  out  1 each  to memory enable, read and write pins.
- `memDataOut`  in  DATA_W  from memory `dataOut`.

## Operation
- States: IDLE, RD, RD_WAIT, WR, DONE.
- IDLE: `start`=1 latches `isLoad`, `baseAddr` and `len`, and clears the word counter `cnt`. The next state is RD if `isLoad`=1, otherwise WR.
- RD: `En`=`MemR`=1, `memAddress`=`base+cnt`. `cnt` increments every cycle. After the word with `cnt==len` is issued, the next state is RD_WAIT.
- Read return path: `memDataOut` is registered into `rdData` one cycle after the memory edge that read it, and `rdValid` is pulsed with it. Words are returned in issue order with no gaps.
- RD_WAIT: no memory access. Goes to DONE.
- WR: `wrReady`=1. When `wrValid`=1 in a cycle:
  - `En`=`MemW`=1, `memAddress`=`base+cnt`, `memDataIn`=`wrData` (combinational pass-through), and `cnt` increments.
  - After the word with `cnt==len` is written, the next state is DONE.
- WR stall: when `wrValid`=0, `En`=`MemW`=0 and the state stays WR. There is no timeout.
- DONE: `done`=1 and `busy`=1 (the final `rdValid` of a read burst falls in this cycle). Next state is IDLE.
- Address arithmetic is modulo 2^ADDR_W: `0xFFFF+1` wraps to `0x0000`. `cnt` is LEN_W bits and never wraps within a burst.
- Invariants:
  - `MemR` and `MemW` are never both 1.
  - `En`=0 forces `MemR`=`MemW`=0.
  - `memAddress`/`memDataIn` are don't-care when `En`=0 but drive 0 in IDLE.
- `start` when `busy`=1, including in the DONE cycle, is ignored with no side effects.
- Reset values: state IDLE, and `busy`, `done`, `wrReady`, `rdValid`, `En`, `MemR`, `MemW`=0, `rdData`, `memAddress`, `memDataIn`=0.

## Timing
- Cycle 0 is the acceptance cycle (`start`=1 while `busy`=0).
- Read, word i (0..len):
  - `En`/`MemR` are asserted in cycle 1+i.
  - The memory `dataOut` is valid in cycle 2+i.
  - `rdValid`/`rdData` appear in cycle 3+i.
  - `done` is in cycle len+3; `busy` is high in cycles 1..len+3.
  - The earliest next `start` is accepted in cycle len+4.
- Write with `wrValid` held high: writes occur in cycles 1..len+1 and `done` is in cycle len+2. Each cycle with `wrValid`=0 adds one cycle.
- `busy` and the memory pins are decoded from registered state only. `memDataIn` and the write `En` additionally depend combinationally on `wrValid`/`wrData`.
- Asserting `rst_n` mid-burst immediately forces all outputs to their reset values (`En` drops in the same cycle). The burst is abandoned; words already written stay in memory and no further words are written.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> all outputs 0, no `En` pulse. Release -> `busy` stays 0 until `start`.
- Single read: memory[9]=0x0044; `start`, `isLoad`=1, `baseAddr`=0x0009, `len`=0 -> `En`/`MemR` with address 0x0009 in cycle 1; `rdValid`=1, `rdData`=0x0044 and `done`=1 in cycle 3; `busy`=0 in cycle 4.
- Burst read: memory[0..3]=0x000A, 0x0014, 0x0028, 0x003C; `baseAddr`=0, `len`=3 -> `rdValid` in cycles 3–6 with those values in order; `done` in cycle 6.
- Wrapping write with stalls:
  - Stimulus: `baseAddr`=0xFFFF, `len`=2, data 0x1111, 0x2222, 0x3333, with `wrValid` low for 2 cycles before the second word.
  - Write response: addresses 0xFFFF, 0x0000, 0x0001; no `En` during the stall; `done` in cycle 6.
  - Readback: a read burst of the same addresses returns the written data.
- `start` pulsed while `busy` (mid-burst and in the DONE cycle) -> ignored; the current burst completes unchanged and no second burst runs.
- Reset mid-burst: assert `rst_n`=0 during the second word of a 4-word write -> `En`=0 in the same cycle and `busy`=0; memory shows only the first word written.
